// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with pixel-source latency alignment.
// Define VGA_TEST_PATTERN_EN to add selectable 8-bar colour pattern on test_mode.
module vga_timing_gen #(
   parameter int   H_VISIBLE = 1600,
   parameter int   H_FP      = 64,
   parameter int   H_SYNC    = 192,
   parameter int   H_BP      = 304,
   parameter int   V_VISIBLE = 1200,
   parameter int   V_FP      = 1,
   parameter int   V_SYNC    = 3,
   parameter int   V_BP      = 46,
   parameter logic H_POL     = 1'b0,
   parameter logic V_POL     = 1'b0,
   parameter int   PIPE_LAT  = 2,
   parameter int   CW        = 4,
   parameter int   X_W       = 12,
   parameter int   Y_W       = 11
) (
   input  logic              clock_162,
   input  logic              rst,
   input  logic [3*CW-1:0]   pix_rgb,
   input  logic              test_mode,
   output logic [X_W-1:0]    pix_x,
   output logic [Y_W-1:0]    pix_y,
   output logic              pix_req,
   output logic              frame_start,
   output logic              line_start,
   output logic [CW-1:0]     RED,
   output logic [CW-1:0]     GREEN,
   output logic [CW-1:0]     BLUE,
   output logic              HSYNC,
   output logic              VSYNC
);
   localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_B  = H_VISIBLE + H_FP;
   localparam int HS_E  = HS_B + H_SYNC;
   localparam int VS_B  = V_VISIBLE + V_FP;
   localparam int VS_E  = VS_B + V_SYNC;
`ifdef VGA_TEST_PATTERN_EN
   localparam int SW = X_W + 3;
`else
   localparam int SW = 3;
`endif
   logic [X_W-1:0]  h_cnt;
   logic [Y_W-1:0]  v_cnt;
   logic [31:0]     hx, vy;
   logic            h_last, v_last, active, hs_raw, vs_raw;
   logic [SW-1:0]   s0, stg;
   logic [3*CW-1:0] colour;
   assign hx     = 32'(h_cnt);
   assign vy     = 32'(v_cnt);
   assign h_last = hx == H_TOT - 1;
   assign v_last = vy == V_TOT - 1;
   always_ff @(posedge clock_162) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_last ? '0 : h_cnt + 1'b1;
         if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
   end
   assign active      = (hx < H_VISIBLE) && (vy < V_VISIBLE);
   assign hs_raw      = (hx >= HS_B) && (hx < HS_E);
   assign vs_raw      = (vy >= VS_B) && (vy < VS_E);
   assign pix_req     = active;
   assign pix_x       = active ? h_cnt : '0;
   assign pix_y       = active ? v_cnt : '0;
   assign frame_start = (h_cnt == '0) && (v_cnt == '0);
   assign line_start  = (h_cnt == '0) && (vy < V_VISIBLE);
`ifdef VGA_TEST_PATTERN_EN
   assign s0 = {h_cnt, active, hs_raw, vs_raw};
`else
   assign s0 = {active, hs_raw, vs_raw};
`endif
   // Timing flags ride alongside the source's read latency; reset flushes them to blank/inactive.
   generate
      if (PIPE_LAT == 0) begin : g_nolat
         assign stg = s0;
      end else begin : g_lat
         logic [SW-1:0] sr [PIPE_LAT];
         always_ff @(posedge clock_162) begin
            sr[0] <= rst ? '0 : s0;
            for (int i = 1; i < PIPE_LAT; i++) sr[i] <= rst ? '0 : sr[i-1];
         end
         assign stg = sr[PIPE_LAT-1];
      end
   endgenerate
`ifdef VGA_TEST_PATTERN_EN
   localparam int          BAR_W = H_VISIBLE / 8;
   // bar 0 (left) .. bar 7 (right) as {R,G,B} on/off: white,yellow,cyan,green,magenta,red,blue,black
   localparam logic [23:0] BARS  = 24'b000_001_100_101_010_011_110_111;
   logic [31:0] bar_n;
   logic [2:0]  bar_idx, bar;
   assign bar_n   = 32'(stg[SW-1:3]) / BAR_W;
   assign bar_idx = bar_n > 7 ? 3'd7 : bar_n[2:0];
   assign bar     = BARS[3*bar_idx +: 3];
   assign colour  = test_mode ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}} : pix_rgb;
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign colour = pix_rgb;
`endif
   always_ff @(posedge clock_162) begin
      if (rst) begin
         {RED, GREEN, BLUE} <= '0;
         HSYNC <= ~H_POL;
         VSYNC <= ~V_POL;
      end else begin
         {RED, GREEN, BLUE} <= stg[2] ? colour : '0;
         HSYNC <= stg[1] ? H_POL : ~H_POL;
         VSYNC <= stg[0] ? V_POL : ~V_POL;
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized scoreboard bench for vga_timing_gen on a shrunken raster.
// An echoing pixel source and random resets drive the DUT; expectations come from a frame-position model.
module tb_vga_timing_gen;
   localparam int HV = 16, HFP = 2, HSW = 3, HBP = 4;
   localparam int VV = 6, VFP = 1, VSW = 2, VBP = 1;
   localparam int LAT = 2;
   localparam int HT = HV + HFP + HSW + HBP;
   localparam int VT = VV + VFP + VSW + VBP;
   localparam int N  = 3200;

   typedef struct {int due; logic [11:0] v;} s0_t;
   typedef struct {int due; logic [11:0] rgb; logic hs; logic vs;} pin_t;

   logic        clock_162 = 1'b0;
   logic        rst = 1'b1;
   logic        test_mode = 1'b0;
   logic [11:0] pix_rgb = '0;
   logic [4:0]  pix_x;
   logic [3:0]  pix_y;
   logic        pix_req, frame_start, line_start, HSYNC, VSYNC;
   logic [3:0]  RED, GREEN, BLUE;

   int          cyc = 0, n_chk = 0, n_pass = 0;
   logic [11:0] key;
   s0_t         q0[$];
   pin_t        qp[$];

   always #5 clock_162 = ~clock_162;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .H_POL(1'b0), .V_POL(1'b1), .PIPE_LAT(LAT), .CW(4), .X_W(5), .Y_W(4)
   ) dut (
      .clock_162(clock_162), .rst(rst), .pix_rgb(pix_rgb), .test_mode(test_mode),
      .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .frame_start(frame_start),
      .line_start(line_start), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
      .HSYNC(HSYNC), .VSYNC(VSYNC)
   );

   function automatic logic [11:0] g(int x, int y);
      return {4'(x) ^ key[11:8], 4'(y) ^ key[7:4], 4'(x + y) ^ key[3:0]};
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
   endtask

   // monitor: pops every expectation that falls due in the current cycle
   initial begin
      s0_t  e0;
      pin_t e1;
      forever begin
         @(negedge clock_162);
         #1;
         while (q0.size() > 0 && q0[0].due == cyc) begin
            e0 = q0.pop_front();
            chk("stage0{req,x,y,fs,ls}", {20'b0, pix_req, pix_x, pix_y, frame_start, line_start}, {20'b0, e0.v});
         end
         while (qp.size() > 0 && qp[0].due == cyc) begin
            e1 = qp.pop_front();
            chk("pins{rgb,hs,vs}", {18'b0, RED, GREEN, BLUE, HSYNC, VSYNC}, {18'b0, e1.rgb, e1.hs, e1.vs});
         end
      end
   end

   // stimulus + reference model
   initial begin
      int   mx, my;
      logic act, r, mid_done, in_h, in_v;
      logic sr_req[2];
      int   sr_x[2], sr_y[2];
      pin_t t;
      key = 12'($urandom);
      mx = 0; my = 0; mid_done = 1'b0;
      sr_req[0] = 1'b0; sr_req[1] = 1'b0;
      sr_x[0] = 0; sr_x[1] = 0; sr_y[0] = 0; sr_y[1] = 0;
      repeat (2) @(negedge clock_162);
      chk("reset_rgb", {20'b0, RED, GREEN, BLUE}, 32'h0);
      chk("reset_hsync", {31'b0, HSYNC}, 32'h1);
      chk("reset_vsync", {31'b0, VSYNC}, 32'h0);
      chk("reset_frame_start", {31'b0, frame_start}, 32'h1);
      chk("reset_pix_req", {31'b0, pix_req}, 32'h1);
      for (int k = 0; k < N + LAT + 3; k++) begin
         act  = (mx < HV) && (my < VV);
         in_h = (mx >= HV + HFP) && (mx < HV + HFP + HSW);
         in_v = (my >= VV + VFP) && (my < VV + VFP + VSW);
         if (cyc < N) begin
            q0.push_back('{cyc, {act, act ? 5'(mx) : 5'd0, act ? 4'(my) : 4'd0,
                                 (mx == 0) && (my == 0), (mx == 0) && (my < VV)}});
            qp.push_back('{cyc + LAT + 1, act ? g(mx, my) : 12'h0, ~in_h, in_v});
         end
         pix_rgb = sr_req[1] ? g(sr_x[1], sr_y[1]) : 12'($urandom);
         sr_req[1] = sr_req[0]; sr_x[1] = sr_x[0]; sr_y[1] = sr_y[0];
         sr_req[0] = pix_req;   sr_x[0] = int'(pix_x); sr_y[0] = int'(pix_y);
         r = 1'b0;
         if (cyc < N) begin
            if (cyc == 0) r = 1'b1;
            if (!mid_done && cyc > 600 && mx == 8 && my == 3) begin
               r = 1'b1;
               mid_done = 1'b1;
            end
            if (cyc >= 150 && cyc < 2200 && $urandom_range(249) == 0) r = 1'b1;
         end
         rst = r;
         if (r)
            foreach (qp[i])
               if (qp[i].due > cyc) begin
                  t = qp[i];
                  t.rgb = '0; t.hs = 1'b1; t.vs = 1'b0;
                  qp[i] = t;
               end
         if (r) begin
            mx = 0; my = 0;
         end else begin
            mx++;
            if (mx == HT) begin
               mx = 0;
               my = (my == VT - 1) ? 0 : my + 1;
            end
         end
         @(negedge clock_162);
         cyc++;
      end
      #2;
      chk("scoreboard_drained", 32'(q0.size() + qp.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
